// File: rtl/feature_ratio_sched_if.sv
// Bus between the blob/bbox tracker, the ratio scheduler and the classifier.
// The master drives the frame-end inputs. The slave (the scheduler) drives the per-frame results.
interface feature_ratio_sched_if #(
  parameter int AREA_W = 23
);
  logic              i_vs;
  logic [11:0]       hcount_l;
  logic [11:0]       hcount_r;
  logic [11:0]       vcount_l;
  logic [11:0]       vcount_r;
  logic [AREA_W-1:0] area_in;
  logic [11:0]       long_side;
  logic [AREA_W-1:0] area_q;
  logic [7:0]        aspect_q;
  logic [7:0]        fill_q;
  logic [1:0]        div0_flags;
  logic              feat_valid;
  logic              busy;
  logic              frame_drop;

  modport master (
    output i_vs, hcount_l, hcount_r, vcount_l, vcount_r, area_in,
    input  long_side, area_q, aspect_q, fill_q, div0_flags, feat_valid, busy, frame_drop
  );

  modport slave (
    input  i_vs, hcount_l, hcount_r, vcount_l, vcount_r, area_in,
    output long_side, area_q, aspect_q, fill_q, div0_flags, feat_valid, busy, frame_drop
  );
endinterface

// File: rtl/feature_ratio_sched.sv
// Frame-end feature scheduler. It captures the bbox and blob area on each VS falling edge.
// One restoring divider is then time-shared for two ratios:
//   aspect = long*16/short
//   fill   = long*short*16/area
// Both are saturated to 8 bits with 4 fractional bits and are reported with a one-cycle strobe.
module feature_ratio_sched #(
  parameter int DIV_W  = 28,
  parameter int AREA_W = 23
) (
  input  logic                 pixelclk,
  input  logic                 rst_n,
  feature_ratio_sched_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    PREP,
    DIV_A,
    DIV_F,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              vs_r;
  logic              vs_fall;
  logic              busy_c;

  logic [CNT_W-1:0]  cnt_q;
  logic              div_zero_q;
  logic              div_last;

  logic [11:0]       w_p0;
  logic [11:0]       h_p0;
  logic [AREA_W-1:0] area_p0;

  logic [11:0]       long_c;
  logic [11:0]       short_c;
  logic [11:0]       long_p1;
  logic [23:0]       prod_p1;

  logic [DIV_W-1:0]  dvd_q;
  logic [AREA_W-1:0] dvs_q;
  logic [AREA_W-1:0] rem_q;
  logic              rem_carry;
  logic [AREA_W-1:0] rem_shift;
  logic              q_bit;
  logic [AREA_W-1:0] rem_nx;
  logic [DIV_W-1:0]  dvd_nx;

  logic [7:0]        aspect_p2;
  logic              flag_a_p2;

  // Quotients above 255 pin to the 8-bit ceiling.
  function automatic logic [7:0] sat8(input logic [DIV_W-1:0] q);
    return (q > DIV_W'(255)) ? 8'hFF : q[7:0];
  endfunction

  // A bbox edge pair that is out of order means an empty extent.
  function automatic logic [11:0] extent(input logic [11:0] lo, input logic [11:0] hi);
    return (hi < lo) ? 12'd0 : hi - lo;
  endfunction

  assign vs_fall = !bus.i_vs && vs_r;
  assign busy_c  = (state_q != IDLE);
  assign bus.busy = busy_c;

  // A zero divisor finishes its slot after a single cycle.
  assign div_last = div_zero_q || (cnt_q == CNT_W'(DIV_W - 1));

  // On a tie the long and short sides are both the width.
  assign long_c  = (w_p0 >= h_p0) ? w_p0 : h_p0;
  assign short_c = (w_p0 >= h_p0) ? h_p0 : w_p0;

  // One restoring step per cycle.
  // A carry out of the shifted remainder already guarantees that the divisor fits.
  assign rem_carry = rem_q[AREA_W-1];
  assign rem_shift = {rem_q[AREA_W-2:0], dvd_q[DIV_W-1]};
  assign q_bit     = rem_carry || (rem_shift >= dvs_q);
  assign rem_nx    = q_bit ? (rem_shift - dvs_q) : rem_shift;
  assign dvd_nx    = {dvd_q[DIV_W-2:0], q_bit};

  // VS delay register for falling-edge detection
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) vs_r <= 1'b0;
    else        vs_r <= bus.i_vs;
  end

  // FSM state register
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vs_fall) state_d = CAPTURE;
      CAPTURE: state_d = PREP;
      PREP:    state_d = DIV_A;
      DIV_A:   if (div_last) state_d = DIV_F;
      DIV_F:   if (div_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divider step counter and zero-divisor shortcut flag
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        PREP: begin
          cnt_q      <= '0;
          div_zero_q <= (short_c == 12'd0);
        end
        DIV_A: begin
          if (div_last) begin
            cnt_q      <= '0;
            div_zero_q <= (area_p0 == '0);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DIV_F:   cnt_q <= cnt_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Datapath: capture, prep and the shared divider
  always_ff @(posedge pixelclk) begin
    case (state_q)
      // ---- p0: capture one cycle after detect, once upstream area has settled ----
      CAPTURE: begin
        w_p0    <= extent(bus.hcount_l, bus.hcount_r);
        h_p0    <= extent(bus.vcount_l, bus.vcount_r);
        area_p0 <= bus.area_in;
      end
      // ---- p1: order the sides, form the product and load the aspect division ----
      PREP: begin
        long_p1 <= long_c;
        prod_p1 <= 24'(long_c) * 24'(short_c);
        dvd_q   <= DIV_W'({long_c, 4'b0000});
        dvs_q   <= AREA_W'(short_c);
        rem_q   <= '0;
      end
      // ---- p2: aspect division, then reload the divider for fill ----
      DIV_A: begin
        if (div_last) begin
          aspect_p2 <= div_zero_q ? 8'hFF : sat8(dvd_nx);
          flag_a_p2 <= div_zero_q;
          dvd_q     <= DIV_W'({prod_p1, 4'b0000});
          dvs_q     <= area_p0;
          rem_q     <= '0;
        end else begin
          dvd_q <= dvd_nx;
          rem_q <= rem_nx;
        end
      end
      DIV_F: begin
        dvd_q <= dvd_nx;
        rem_q <= rem_nx;
      end
      default: ;
    endcase
  end

  // ---- result stage: all outputs update together as the FSM enters DONE ----
  // Result registers and the strobe/drop pulses
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      bus.long_side  <= '0;
      bus.area_q     <= '0;
      bus.aspect_q   <= '0;
      bus.fill_q     <= '0;
      bus.div0_flags <= '0;
      bus.feat_valid <= 1'b0;
      bus.frame_drop <= 1'b0;
    end else begin
      bus.feat_valid <= 1'b0;
      bus.frame_drop <= vs_fall && busy_c;
      if (state_q == DIV_F && div_last) begin
        bus.long_side  <= long_p1;
        bus.area_q     <= area_p0;
        bus.aspect_q   <= aspect_p2;
        bus.fill_q     <= div_zero_q ? 8'hFF : sat8(dvd_nx);
        bus.div0_flags <= {div_zero_q, flag_a_p2};
        bus.feat_valid <= 1'b1;
      end
    end
  end

endmodule
